// File: rtl/pea_pkg.sv
// Shared definitions for the partial-sum accumulation buffer:
// default widths/latencies, drain-state encoding and lane helpers.
package pea_pkg;

  localparam int COL_DEF      = 8;
  localparam int TILE_LEN_DEF = 16;
  localparam int PSUM_W_DEF   = 16;
  localparam int ACC_W_DEF    = 24;
  localparam int PV_LAT_DEF   = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

  // Sign-extend one PE partial sum to accumulator width.
  function automatic logic [ACC_W_DEF-1:0] sext_psum(input logic [PSUM_W_DEF-1:0] v);
    return {{(ACC_W_DEF-PSUM_W_DEF){v[PSUM_W_DEF-1]}}, v};
  endfunction

  // Clamp a negative accumulation to zero.
  function automatic logic [ACC_W_DEF-1:0] relu_acc(input logic [ACC_W_DEF-1:0] v);
    logic [ACC_W_DEF-1:0] r;
    if (v[ACC_W_DEF-1]) begin
      r = '0;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/psum_acc_buf_if.sv
// Drain stream from the accumulation buffer to the output writer.
// master = buffer (drives beats), slave = writer (drives out_ready).
interface psum_acc_buf_if #(
  parameter int COL   = 8,
  parameter int ACC_W = 24
) ();
  logic                 out_valid;
  logic                 out_ready;
  logic [COL*ACC_W-1:0] out_data;
  logic [COL-1:0]       out_lane;
  logic                 out_last;
  logic                 out_conv_last;

  modport master (
    output out_valid, out_data, out_lane, out_last, out_conv_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_lane, out_last, out_conv_last,
    output out_ready
  );
endinterface

// File: rtl/psum_bank.sv
// One TILE_LEN x COL accumulator bank: per-lane overwrite or
// accumulate write port, combinational read port. Contents are not
// reset; every tile starts with an overwriting first pass.
module psum_bank
  import pea_pkg::*;
#(
  parameter int COL      = COL_DEF,
  parameter int TILE_LEN = TILE_LEN_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  localparam int AW      = $clog2(TILE_LEN)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [COL-1:0]       wr_lane,
  input  logic                 wr_ovw,
  input  logic [COL*ACC_W-1:0] wr_data,
  input  logic [AW-1:0]        rd_addr,
  output logic [COL*ACC_W-1:0] rd_data
);

  logic [COL*ACC_W-1:0] mem_r [TILE_LEN];

  // Per-lane overwrite (first pass) or wrapping accumulate (later passes).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int c = 0; c < COL; c++) begin
        if (wr_lane[c]) begin
          if (wr_ovw) begin
            mem_r[wr_addr][c*ACC_W +: ACC_W] <= wr_data[c*ACC_W +: ACC_W];
          end else begin
            mem_r[wr_addr][c*ACC_W +: ACC_W] <= mem_r[wr_addr][c*ACC_W +: ACC_W]
                                              + wr_data[c*ACC_W +: ACC_W];
          end
        end
      end
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/psum_acc_buf.sv
// Partial-sum accumulation buffer: aligns controller pass markers with
// the pvalid stream, accumulates input-channel passes into one of two
// banks and drains finished output-channel tiles as a COL-lane stream.
// Optional build macro: PSUM_RELU_EN (zero negative lanes on readout).
module psum_acc_buf
  import pea_pkg::*;
#(
  parameter int COL      = COL_DEF,
  parameter int TILE_LEN = TILE_LEN_DEF,
  parameter int PSUM_W   = PSUM_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int PV_LAT   = PV_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_conv,
  input  logic                  ic_done,
  input  logic                  oc_done,
  input  logic                  conv_done,
  input  logic [COL-1:0]        psum_vld,
  input  logic [COL*PSUM_W-1:0] psum_in,
  psum_acc_buf_if.master        out_if,
  output logic                  busy,
  output logic                  err_ovf
);

  localparam int AW = $clog2(TILE_LEN);
  localparam int PW = $clog2(TILE_LEN + 1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);
  localparam logic [AW-1:0] RD_ONE  = AW'(1'b1);
  localparam logic [PW-1:0] PTR_MAX = PW'(TILE_LEN);

  // Marker alignment
  logic [PV_LAT-1:0] ic_sr_r, oc_sr_r, cv_sr_r;
  logic              ic_d_s, oc_d_s, cv_d_s;

  // Write side
  logic [PW-1:0]        wr_ptr_r;
  logic                 wr_bank_r;
  logic                 first_pass_r;
  logic [COL-1:0]       lane_msk_r;
  logic                 beat_s, full_s, wr_en_s, ovf_beat_s, req_s;
  logic [PW-1:0]        cnt_s;
  logic [COL-1:0]       lane_acc_s;
  logic [COL*ACC_W-1:0] wr_data_s;
  logic [1:0]           bank_we_s;
  logic [COL*ACC_W-1:0] bank_rd_s [2];

  // Drain side
  drain_state_e         state_r, state_nx_s;
  logic [AW-1:0]        rd_ptr_r, rd_ptr_nx_s;
  logic                 rd_bank_r, rd_bank_nx_s;
  logic [PW-1:0]        rd_len_r, rd_len_nx_s;
  logic [COL-1:0]       rd_lane_r, rd_lane_nx_s;
  logic                 rd_cv_r, rd_cv_nx_s;
  logic                 overrun_s, last_s;
  logic                 err_ovf_r;
  logic [COL*ACC_W-1:0] out_data_s;

  // Delay controller markers so they coincide with their last pvalid beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ic_sr_r <= '0;
      oc_sr_r <= '0;
      cv_sr_r <= '0;
    end else begin
      ic_sr_r <= {ic_sr_r[PV_LAT-2:0], ic_done};
      oc_sr_r <= {oc_sr_r[PV_LAT-2:0], oc_done};
      cv_sr_r <= {cv_sr_r[PV_LAT-2:0], conv_done};
    end
  end

  assign ic_d_s = ic_sr_r[PV_LAT-1];
  assign oc_d_s = oc_sr_r[PV_LAT-1];
  assign cv_d_s = cv_sr_r[PV_LAT-1];

  // Beat qualification, overflow detection and sign-extended write data.
  always_comb begin
    beat_s     = |psum_vld;
    full_s     = (wr_ptr_r == PTR_MAX);
    wr_en_s    = beat_s & ~full_s;
    ovf_beat_s = beat_s & full_s;
    lane_acc_s = lane_msk_r | psum_vld;
    wr_data_s  = '0;
    if (wr_en_s) begin
      cnt_s = wr_ptr_r + PTR_ONE;
    end else begin
      cnt_s = wr_ptr_r;
    end
    for (int c = 0; c < COL; c++) begin
      wr_data_s[c*ACC_W +: ACC_W] = sext_psum(psum_in[c*PSUM_W +: PSUM_W]);
    end
    // A tile with no beats produces no drain.
    req_s = oc_d_s & (cnt_s != '0);
  end

  // Pass/tile bookkeeping: pointer, bank select, first-pass flag, lane mask.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r     <= '0;
      wr_bank_r    <= 1'b0;
      first_pass_r <= 1'b1;
      lane_msk_r   <= '0;
    end else begin
      if (oc_d_s) begin
        wr_bank_r    <= ~wr_bank_r;
        first_pass_r <= 1'b1;
        wr_ptr_r     <= '0;
        lane_msk_r   <= '0;
      end else if (ic_d_s) begin
        first_pass_r <= 1'b0;
        wr_ptr_r     <= '0;
        lane_msk_r   <= '0;
      end else begin
        wr_ptr_r     <= cnt_s;
        lane_msk_r   <= lane_acc_s;
      end
      // New convolution restarts the pass without disturbing a drain.
      if (start_conv) begin
        wr_ptr_r     <= '0;
        first_pass_r <= 1'b1;
        lane_msk_r   <= '0;
      end
    end
  end

  assign bank_we_s = {wr_en_s & wr_bank_r, wr_en_s & ~wr_bank_r};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    psum_bank #(
      .COL      (COL),
      .TILE_LEN (TILE_LEN),
      .ACC_W    (ACC_W)
    ) u_bank (
      .clk     (clk),
      .wr_en   (bank_we_s[b]),
      .wr_addr (wr_ptr_r[AW-1:0]),
      .wr_lane (psum_vld),
      .wr_ovw  (first_pass_r),
      .wr_data (wr_data_s),
      .rd_addr (rd_ptr_r),
      .rd_data (bank_rd_s[b])
    );
  end

  assign last_s = (rd_ptr_r == rd_len_r[AW-1:0] - RD_ONE) && (rd_len_r != '0);

  // Drain FSM next state; a new request always (re)starts from beat 0.
  always_comb begin
    state_nx_s   = state_r;
    rd_ptr_nx_s  = rd_ptr_r;
    rd_bank_nx_s = rd_bank_r;
    rd_len_nx_s  = rd_len_r;
    rd_lane_nx_s = rd_lane_r;
    rd_cv_nx_s   = rd_cv_r;
    overrun_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          state_nx_s = DRAIN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      DRAIN: begin
        if (req_s) begin
          overrun_s = 1'b1;
        end else if (out_if.out_ready && last_s) begin
          state_nx_s = IDLE;
        end else if (out_if.out_ready) begin
          rd_ptr_nx_s = rd_ptr_r + RD_ONE;
        end else begin
          state_nx_s = DRAIN;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
    if (req_s) begin
      state_nx_s   = DRAIN;
      rd_ptr_nx_s  = '0;
      rd_bank_nx_s = wr_bank_r;
      rd_len_nx_s  = cnt_s;
      rd_lane_nx_s = lane_acc_s;
      rd_cv_nx_s   = cv_d_s;
    end else begin
      rd_cv_nx_s   = rd_cv_nx_s;
    end
  end

  // Drain FSM state and read-descriptor registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= IDLE;
      rd_ptr_r  <= '0;
      rd_bank_r <= 1'b0;
      rd_len_r  <= '0;
      rd_lane_r <= '0;
      rd_cv_r   <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      rd_ptr_r  <= rd_ptr_nx_s;
      rd_bank_r <= rd_bank_nx_s;
      rd_len_r  <= rd_len_nx_s;
      rd_lane_r <= rd_lane_nx_s;
      rd_cv_r   <= rd_cv_nx_s;
    end
  end

  // Sticky error: dropped beat on a full pass or a tile overrunning a drain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_ovf_r <= 1'b0;
    end else if (ovf_beat_s || overrun_s) begin
      err_ovf_r <= 1'b1;
    end else if (start_conv) begin
      err_ovf_r <= 1'b0;
    end
  end

  // Read path: bank mux, optional clamp, zero outside of a drain.
  always_comb begin
    out_data_s = '0;
    if (state_r == DRAIN) begin
      for (int c = 0; c < COL; c++) begin
`ifdef PSUM_RELU_EN
        out_data_s[c*ACC_W +: ACC_W] = relu_acc(bank_rd_s[rd_bank_r][c*ACC_W +: ACC_W]);
`else
        out_data_s[c*ACC_W +: ACC_W] = bank_rd_s[rd_bank_r][c*ACC_W +: ACC_W];
`endif
      end
    end else begin
      out_data_s = '0;
    end
  end

  assign out_if.out_valid     = (state_r == DRAIN);
  assign out_if.out_data      = out_data_s;
  assign out_if.out_lane      = (state_r == DRAIN) ? rd_lane_r : '0;
  assign out_if.out_last      = (state_r == DRAIN) & last_s;
  assign out_if.out_conv_last = (state_r == DRAIN) & last_s & rd_cv_r;
  assign busy                 = (state_r == DRAIN);
  assign err_ovf              = err_ovf_r;

endmodule

// File: tb/tb_psum_acc_buf.sv
// Directed bench for psum_acc_buf: multi-pass accumulation, lane
// masks, strided beats, drain overrun, pass overflow, end-of-conv flag
// and asynchronous reset during a drain.
`timescale 1ns/1ps
module tb_psum_acc_buf;

  localparam int COL    = 8;
  localparam int PSUM_W = 16;
  localparam int ACC_W  = 24;
  localparam int PV_LAT = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start_conv = 1'b0;
  logic ic_done = 1'b0;
  logic oc_done = 1'b0;
  logic conv_done = 1'b0;
  logic [COL-1:0] psum_vld = '0;
  logic [COL*PSUM_W-1:0] psum_in = '0;
  logic busy;
  logic err_ovf;

  int checks = 0;
  int failures = 0;

  psum_acc_buf_if #(.COL(COL), .ACC_W(ACC_W)) ob ();

  psum_acc_buf dut (
    .clk        (clk),
    .rstn       (rstn),
    .start_conv (start_conv),
    .ic_done    (ic_done),
    .oc_done    (oc_done),
    .conv_done  (conv_done),
    .psum_vld   (psum_vld),
    .psum_in    (psum_in),
    .out_if     (ob.master),
    .busy       (busy),
    .err_ovf    (err_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One ic pass: n beats spaced by gap idle cycles; markers are issued
  // PV_LAT cycles ahead of the last beat, as the controller does.
  task automatic drive_pass(input int n, input int gap, input logic [15:0] val,
                            input logic [7:0] mask, input bit ic, input bit oc, input bit cv);
    int last_k;
    int k0;
    last_k = (n - 1) * (gap + 1);
    k0 = (last_k - PV_LAT < 0) ? (last_k - PV_LAT) : 0;
    for (int k = k0; k <= last_k; k++) begin
      @(negedge clk);
      psum_vld  = (k >= 0 && (k % (gap + 1)) == 0) ? mask : 8'h00;
      psum_in   = {COL{val}};
      ic_done   = ic && (k == last_k - PV_LAT);
      oc_done   = oc && (k == last_k - PV_LAT);
      conv_done = cv && (k == last_k - PV_LAT);
    end
    @(negedge clk);
    psum_vld  = '0;
    psum_in   = '0;
    ic_done   = 1'b0;
    oc_done   = 1'b0;
    conv_done = 1'b0;
  endtask

  // Expect n drain beats starting now (out_ready must already be high).
  task automatic drain_check(input string tag, input int n, input logic [23:0] exp_val,
                             input logic [7:0] mask, input bit cv);
    for (int b = 0; b < n; b++) begin
      chk($sformatf("%s valid b%0d", tag, b), 32'(ob.out_valid), 32'd1);
      chk($sformatf("%s lane b%0d", tag, b), 32'(ob.out_lane), 32'(mask));
      chk($sformatf("%s last b%0d", tag, b), 32'(ob.out_last), 32'(b == n - 1));
      chk($sformatf("%s conv_last b%0d", tag, b), 32'(ob.out_conv_last), 32'(cv && (b == n - 1)));
      for (int c = 0; c < COL; c++) begin
        if (mask[c]) begin
          chk($sformatf("%s data b%0d c%0d", tag, b, c),
              32'(ob.out_data[c*ACC_W +: ACC_W]), 32'(exp_val));
        end
      end
      @(negedge clk);
    end
    chk($sformatf("%s idle valid", tag), 32'(ob.out_valid), 32'd0);
    chk($sformatf("%s idle busy", tag), 32'(busy), 32'd0);
  endtask

  logic [23:0] neg15_exp;

  initial begin
`ifdef PSUM_RELU_EN
    neg15_exp = 24'd0;
`else
    neg15_exp = 24'hFFFFF1;
`endif
    ob.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst valid", 32'(ob.out_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst err", 32'(err_ovf), 32'd0);
    chk("rst lane", 32'(ob.out_lane), 32'd0);
    chk("rst last", 32'(ob.out_last), 32'd0);
    chk("rst data", 32'(|ob.out_data), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Two full passes (1 then 2) -> 3 per lane, 16 beats
    drive_pass(16, 0, 16'd1, 8'hFF, 1'b1, 1'b0, 1'b0);
    chk("t1 no drain after ic", 32'(ob.out_valid), 32'd0);
    drive_pass(16, 0, 16'd2, 8'hFF, 1'b1, 1'b1, 1'b0);
    drain_check("t1", 16, 24'd3, 8'hFF, 1'b0);

    // Column-masked single pass, 10 beats
    drive_pass(10, 0, 16'd100, 8'h07, 1'b1, 1'b1, 1'b0);
    drain_check("t2", 10, 24'd100, 8'h07, 1'b0);

    // Strided beats, three passes of -5
    drive_pass(4, 1, 16'hFFFB, 8'hFF, 1'b1, 1'b0, 1'b0);
    drive_pass(4, 1, 16'hFFFB, 8'hFF, 1'b1, 1'b0, 1'b0);
    drive_pass(4, 1, 16'hFFFB, 8'hFF, 1'b1, 1'b1, 1'b0);
    drain_check("t3", 4, neg15_exp, 8'hFF, 1'b0);

    // Final tile of a convolution
    drive_pass(6, 0, 16'd2, 8'hFF, 1'b1, 1'b1, 1'b1);
    drain_check("t6", 6, 24'd2, 8'hFF, 1'b1);

    // Backpressure overrun: a new tile lands while the old one is stalled
    ob.out_ready = 1'b0;
    drive_pass(16, 0, 16'd9, 8'hFF, 1'b1, 1'b1, 1'b0);
    chk("t4 a valid", 32'(ob.out_valid), 32'd1);
    chk("t4 a data", 32'(ob.out_data[ACC_W-1:0]), 32'd9);
    repeat (20) @(negedge clk);
    chk("t4 hold valid", 32'(ob.out_valid), 32'd1);
    chk("t4 hold data", 32'(ob.out_data[ACC_W-1:0]), 32'd9);
    chk("t4 hold last", 32'(ob.out_last), 32'd0);
    chk("t4 no err yet", 32'(err_ovf), 32'd0);
    drive_pass(5, 0, 16'd7, 8'hFF, 1'b1, 1'b1, 1'b0);
    chk("t4 err set", 32'(err_ovf), 32'd1);
    chk("t4 restart data", 32'(ob.out_data[ACC_W-1:0]), 32'd7);
    chk("t4 restart last", 32'(ob.out_last), 32'd0);
    repeat (10) @(negedge clk);
    chk("t4 b busy", 32'(busy), 32'd1);
    ob.out_ready = 1'b1;
    drain_check("t4", 5, 24'd7, 8'hFF, 1'b0);
    start_conv = 1'b1;
    @(negedge clk);
    start_conv = 1'b0;
    chk("t4 err cleared", 32'(err_ovf), 32'd0);

    // 17 beats in one pass: last one dropped
    drive_pass(17, 0, 16'd3, 8'hFF, 1'b1, 1'b1, 1'b0);
    chk("t5 err set", 32'(err_ovf), 32'd1);
    drain_check("t5", 16, 24'd3, 8'hFF, 1'b0);
    start_conv = 1'b1;
    @(negedge clk);
    start_conv = 1'b0;
    chk("t5 err cleared", 32'(err_ovf), 32'd0);

    // Asynchronous reset in the middle of a drain
    drive_pass(8, 0, 16'd1, 8'hFF, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("t7 pre valid", 32'(ob.out_valid), 32'd1);
    rstn = 1'b0;
    #1;
    chk("t7 valid", 32'(ob.out_valid), 32'd0);
    chk("t7 busy", 32'(busy), 32'd0);
    chk("t7 lane", 32'(ob.out_lane), 32'd0);
    chk("t7 data", 32'(|ob.out_data), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("t7 post valid", 32'(ob.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psum_acc_buf.md
Name: psum_acc_buf

Overview:
- Downstream of the PE-array controller: consumes per-column partial sums qualified by pvalid[COL], plus the controller's ic_done/oc_done/conv_done pulses.
- Accumulates partial sums over all input channels of one output-channel tile in a double-buffered accumulator bank.
- Drains each finished tile as a COL-lane valid/ready stream to the output writer.

Parameters:
- COL, 8, PE columns / output lanes
- TILE_LEN, 16, max pixel beats per ic pass
- PSUM_W, 16, PE partial-sum width (signed)
- ACC_W, 24, accumulator/output width (signed)
- PV_LAT, 3, cycles from controller ic_done/oc_done/conv_done to alignment with the matching last pvalid beat

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start_conv  in  1  new convolution; clears err_ovf and first-pass state
- ic_done  in  1  controller end of ic pass (unaligned)
- oc_done  in  1  controller end of oc tile (unaligned)
- conv_done  in  1  controller end of convolution (unaligned)
- psum_vld  in  COL  per-lane beat valid (pvalid)
- psum_in  in  COL*PSUM_W  lane c at [c*PSUM_W +: PSUM_W]
- out_valid  out  1  drain beat valid
- out_ready  in  1  downstream accept
- out_data  out  COL*ACC_W  accumulated pixel vector
- out_lane  out  COL  lanes valid in tile (row mask)
- out_last  out  1  last beat of tile
- out_conv_last  out  1  tile is last of convolution (with out_last)
- busy  out  1  drain in progress
- err_ovf  out  1  sticky error

Behaviour:
- Reset: all outputs 0; wr_ptr=0; wr_bank=0; first_pass=1; drain FSM IDLE.
- Alignment: ic_done, oc_done and conv_done pass through a PV_LAT-stage shift register to give ic_d, oc_d and cv_d. The controller pulses each at most once per cycle.
- Write side: a beat is any cycle with |psum_vld. For each lane c with psum_vld[c]:
  - first_pass=1: bank[wr_bank][wr_ptr][c] = sext(psum_in[c]).
  - first_pass=0: bank[wr_bank][wr_ptr][c] += sext(psum_in[c]), wrapping modulo 2^ACC_W with no saturation.
- wr_ptr increments per beat. On ic_d, wr_ptr clears to 0 after the same-cycle beat, and first_pass clears to 0.
- A beat with wr_ptr==TILE_LEN is discarded and sets err_ovf.
- Per pass, len latches the beat count, and lane_msk latches the OR of psum_vld.
- On oc_d (after the same-cycle beat is written):
  - wr_bank toggles; first_pass=1.
  - Drain request is issued with rd_bank=old wr_bank, rd_len=len, rd_lane=lane_msk, rd_cv=cv_d.
- Drain FSM:
  - IDLE: on request go to DRAIN. out_valid rises the cycle after oc_d. rd_ptr=0.
  - DRAIN: out_data=bank[rd_bank][rd_ptr]; out_lane=rd_lane; out_last=(rd_ptr==rd_len-1); out_conv_last=out_last&rd_cv.
  - In DRAIN, each out_valid&out_ready advances rd_ptr. Accepting the last beat returns to IDLE.
  - Outputs hold stable while out_valid&!out_ready. busy = state==DRAIN.
- Request while DRAIN (backpressure overrun): set err_ovf; abort current drain; restart DRAIN on the new bank with rd_ptr=0.
- rd_len==0 request (no beats): no drain, stay IDLE.
- start_conv: clears err_ovf, wr_ptr and first_pass=1. It does not abort an active drain.
- Reset mid-drain: outputs drop to 0 asynchronously; bank contents are don't-care.

Optional Feature:
- PSUM_RELU_EN defined: out_data lanes with sign bit set are driven 0; combinational on the read path, no added latency.
- Undefined: raw signed accumulations are output.

Decomposition:
- Package pea_pkg: ACC_W, PSUM_W, PV_LAT defaults; drain-state enum (IDLE, DRAIN); sign-extension function.
- Sub-module psum_bank: one TILE_LEN x COL x ACC_W register bank with write-accumulate/overwrite port and combinational read port. It is instantiated twice, and the top muxes between the two instances by wr_bank/rd_bank.

Test Plan:
- Two ic passes, all lanes, 16 beats each, psum=1 then 2, oc_done → 16 beats out_data lanes=3, out_lane=0xFF, out_last on beat 16.
- Single pass, psum_vld=0x07 (row mask), 10 beats (col-masked tile) → 10 beats out, out_lane=0x07, out_last on 10th.
- Stride-2 style: beats every other cycle, psum=-5, 3 passes → out lanes −15; with PSUM_RELU_EN → 0.
- out_ready held low 40 cycles across the next oc_d → err_ovf=1, drain restarts on new bank, rd_ptr=0; start_conv clears err_ovf.
- 17 beats in one pass → 17th ignored, err_ovf=1, drain length 16.
- conv_done with final oc_done → out_conv_last=1 only on final beat. Assert rstn low mid-drain → out_valid=0 immediately.
